// File: rtl/aes_frame_pkg.sv
// Shared constants and state encoding for the SPI-frame to AES-core controller.
package aes_frame_pkg;

    localparam int unsigned FRAME_W   = 392;
    localparam int unsigned PAYLOAD_W = 384;

    localparam logic [1:0] KS_128 = 2'b00;
    localparam logic [1:0] KS_192 = 2'b01;
    localparam logic [1:0] KS_256 = 2'b10;

    localparam logic [7:0] STATUS_OK      = 8'h01;
    localparam logic [7:0] STATUS_BADKEY  = 8'h80;
    localparam logic [7:0] STATUS_TIMEOUT = 8'h81;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        START   = 3'd2,
        WAIT    = 3'd3,
        RESP    = 3'd4,
        ERR     = 3'd5
    } state_t;

endpackage

// File: rtl/frame_unpack.sv
// Maps the frame payload to a right-aligned key and the text block that sits
// directly above the key, for the selected key size.
module frame_unpack
    import aes_frame_pkg::*;
(
    input  logic [PAYLOAD_W-1:0] payload,
    input  logic [1:0]           key_size,
    output logic [255:0]         key,
    output logic [127:0]         text,
    output logic                 size_ok
);

    always_comb begin
        key     = '0;
        text    = '0;
        size_ok = 1'b1;
        case (key_size)
            KS_128: begin
                key[127:0] = payload[127:0];
                text       = payload[255:128];
            end
            KS_192: begin
                key[191:0] = payload[191:0];
                text       = payload[319:192];
            end
            KS_256: begin
                key  = payload[255:0];
                text = payload[383:256];
            end
            default: size_ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/aes_frame_ctrl.sv
// Accepts command frames from the SPI slave, runs one AES operation per frame
// and returns a status/result frame; frames arriving while busy are counted and dropped.
module aes_frame_ctrl
    import aes_frame_pkg::*;
#(
    parameter int unsigned FRAME_W     = aes_frame_pkg::FRAME_W,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [FRAME_W-1:0] frame_in,
    input  logic               frame_valid,
    output logic               aes_start,
    output logic               aes_decrypt,
    output logic [1:0]         aes_key_size,
    output logic [255:0]       aes_key,
    output logic [127:0]       aes_text,
    input  logic               aes_done,
    input  logic [127:0]       aes_result,
    output logic [FRAME_W-1:0] resp_out,
    output logic               resp_valid,
    output logic               busy,
    output logic [7:0]         drop_count
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t             state;
    state_t             state_n;
    logic               fv_low;
    logic               frame_edge;
    logic [FRAME_W-1:0] frame_reg;
    logic [7:0]         cmd;
    logic [CNT_W-1:0]   wait_cnt;
    logic [7:0]         err_status;
    logic               size_ok;
    logic               timed_out;
    logic               unused_cmd;

    function automatic logic [FRAME_W-1:0] pack_resp(input logic [7:0] status,
                                                     input logic [127:0] block);
        pack_resp                 = '0;
        pack_resp[FRAME_W-1 -: 8] = status;
        pack_resp[127:0]          = block;
    endfunction

    // fv_low resets to 0, so a level held high across reset release is not an edge
    assign frame_edge = frame_valid && fv_low;
    assign cmd        = frame_reg[FRAME_W-1 -: 8];
    assign unused_cmd = ^cmd[7:3];
    assign timed_out  = (wait_cnt == WAIT_LAST);

    frame_unpack u_unpack (
        .payload  (frame_reg[PAYLOAD_W-1:0]),
        .key_size (cmd[1:0]),
        .key      (aes_key),
        .text     (aes_text),
        .size_ok  (size_ok)
    );

    assign aes_key_size = cmd[1:0];
    assign aes_decrypt  = cmd[2];
    assign aes_start    = (state == START);
    assign busy         = (state != IDLE);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (frame_edge) state_n = CAPTURE;
            CAPTURE: state_n = size_ok ? START : ERR;
            START:   state_n = WAIT;
            WAIT: begin
                if (aes_done)       state_n = RESP;
                else if (timed_out) state_n = ERR;
            end
            ERR:     state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            fv_low     <= 1'b0;
            frame_reg  <= '0;
            wait_cnt   <= '0;
            err_status <= '0;
            resp_out   <= '0;
            resp_valid <= 1'b0;
            drop_count <= '0;
        end else begin
            state      <= state_n;
            fv_low     <= !frame_valid;
            resp_valid <= (state == RESP);

            if (state == IDLE && frame_edge)
                frame_reg <= frame_in;
            if (state != IDLE && frame_edge && drop_count != 8'hFF)
                drop_count <= drop_count + 8'd1;

            case (state)
                CAPTURE: err_status <= STATUS_BADKEY;
                START:   wait_cnt <= '0;
                WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (aes_done)
                        resp_out <= pack_resp(STATUS_OK, aes_result);
                    else if (timed_out)
                        err_status <= STATUS_TIMEOUT;
                end
                ERR:     resp_out <= pack_resp(err_status, '0);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_frame_ctrl.sv
// Directed self-checking bench for aes_frame_ctrl with a hand-driven AES core.
module tb_aes_frame_ctrl;

    localparam int unsigned FW = 392;
    localparam int unsigned T  = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [FW-1:0] frame_in;
    logic          frame_valid;
    logic          aes_start, aes_decrypt, aes_done, resp_valid, busy;
    logic [1:0]    aes_key_size;
    logic [255:0]  aes_key;
    logic [127:0]  aes_text, aes_result;
    logic [FW-1:0] resp_out;
    logic [7:0]    drop_count;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] K128 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [191:0] K192 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] R128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] R256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    aes_frame_ctrl #(.TIMEOUT_CYC(T)) dut (
        .clk(clk), .reset(reset), .frame_in(frame_in), .frame_valid(frame_valid),
        .aes_start(aes_start), .aes_decrypt(aes_decrypt), .aes_key_size(aes_key_size),
        .aes_key(aes_key), .aes_text(aes_text), .aes_done(aes_done), .aes_result(aes_result),
        .resp_out(resp_out), .resp_valid(resp_valid), .busy(busy), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    function automatic logic [FW-1:0] mk_frame(input logic [7:0] cmd, input logic [255:0] key,
                                               input logic [127:0] text);
        logic [FW-1:0] f;
        f = '0;
        f[391:384] = cmd;
        case (cmd[1:0])
            2'b00: begin f[127:0] = key[127:0]; f[255:128] = text; end
            2'b01: begin f[191:0] = key[191:0]; f[319:192] = text; end
            default: begin f[255:0] = key; f[383:256] = text; end
        endcase
        return f;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // returns in the CAPTURE cycle with frame_valid already dropped
    task automatic send_frame(input logic [FW-1:0] f);
        frame_in    = f;
        frame_valid = 1'b1;
        step();
        frame_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; frame_valid = 1'b1; aes_done = 1'b0;
        aes_result = '0; frame_in = mk_frame(8'h00, {128'h0, K128}, PT);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (aes_start !== 1'b0 || resp_valid !== 1'b0) begin errors++; $display("FAIL reset_pulses got start=%b valid=%b want 0 0", aes_start, resp_valid); end
        checks++; if (resp_out !== '0) begin errors++; $display("FAIL reset_resp_out got %h want 0", resp_out); end
        checks++; if (aes_key !== '0 || aes_text !== '0) begin errors++; $display("FAIL reset_key_text got %h %h want 0", aes_key, aes_text); end
        checks++; if (aes_key_size !== 2'b00 || aes_decrypt !== 1'b0 || drop_count !== 8'd0) begin errors++; $display("FAIL reset_cfg got ks=%b dec=%b drop=%0d want 0", aes_key_size, aes_decrypt, drop_count); end
        step(); step();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL held_high_release cyc %0d busy got %b want 0", i, busy); end
        end
        frame_valid = 1'b0;
        step(); step();
    endtask

    task automatic test_aes128();
        send_frame(mk_frame(8'h00, {128'h0, K128}, PT));
        checks++; if (aes_key !== {128'h0, K128}) begin errors++; $display("FAIL k128_key got %h want %h", aes_key, {128'h0, K128}); end
        checks++; if (aes_text !== PT) begin errors++; $display("FAIL k128_text got %h want %h", aes_text, PT); end
        checks++; if (aes_key_size !== 2'b00 || aes_decrypt !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL k128_cfg got ks=%b dec=%b busy=%b want 00 0 1", aes_key_size, aes_decrypt, busy); end
        step();
        checks++; if (aes_start !== 1'b1) begin errors++; $display("FAIL k128_start got %b want 1", aes_start); end
        step();
        checks++; if (aes_start !== 1'b0) begin errors++; $display("FAIL k128_start_width got %b want 0", aes_start); end
        aes_done = 1'b1; aes_result = R128;
        step();
        aes_done = 1'b0; aes_result = '0;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL k128_valid_early got %b want 0", resp_valid); end
        step();
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL k128_valid got %b want 1", resp_valid); end
        checks++; if (resp_out !== {8'h01, 256'h0, R128}) begin errors++; $display("FAIL k128_resp got %h want %h", resp_out, {8'h01, 256'h0, R128}); end
        step();
        checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL k128_after got valid=%b busy=%b want 0 0", resp_valid, busy); end
        checks++; if (resp_out !== {8'h01, 256'h0, R128}) begin errors++; $display("FAIL k128_resp_hold got %h", resp_out); end
    endtask

    task automatic test_aes256();
        int starts;
        send_frame(mk_frame(8'h02, K256, PT));
        checks++; if (aes_key_size !== 2'b10 || aes_key !== K256 || aes_text !== PT) begin errors++; $display("FAIL k256_cfg got ks=%b key=%h text=%h", aes_key_size, aes_key, aes_text); end
        step();
        starts = (aes_start === 1'b1) ? 1 : 0;
        for (int i = 1; i < 20; i++) begin
            step();
            if (aes_start === 1'b1) starts++;
        end
        step();
        if (aes_start === 1'b1) starts++;
        aes_done = 1'b1; aes_result = R256;
        step();
        aes_done = 1'b0; aes_result = '0;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL k256_valid_early got %b want 0", resp_valid); end
        step();
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL k256_valid_latency got %b want 1", resp_valid); end
        checks++; if (resp_out !== {8'h01, 256'h0, R256}) begin errors++; $display("FAIL k256_resp got %h want %h", resp_out, {8'h01, 256'h0, R256}); end
        checks++; if (starts != 1) begin errors++; $display("FAIL k256_start_count got %0d want 1", starts); end
        checks++; if (aes_key !== K256) begin errors++; $display("FAIL k256_key_hold got %h want %h", aes_key, K256); end
        step();
    endtask

    task automatic test_aes192_decrypt();
        send_frame(mk_frame(8'h05, {64'h0, K192}, PT));
        checks++; if (aes_key !== {64'h0, K192}) begin errors++; $display("FAIL k192_key got %h want %h", aes_key, {64'h0, K192}); end
        checks++; if (aes_text !== PT || aes_key_size !== 2'b01 || aes_decrypt !== 1'b1) begin errors++; $display("FAIL k192_cfg got text=%h ks=%b dec=%b", aes_text, aes_key_size, aes_decrypt); end
        step(); step();
        aes_done = 1'b1; aes_result = 128'hcafef00d_01234567_89abcdef_deadbeef;
        step();
        aes_done = 1'b0;
        step();
        checks++; if (resp_valid !== 1'b1 || resp_out !== {8'h01, 256'h0, 128'hcafef00d_01234567_89abcdef_deadbeef}) begin errors++; $display("FAIL k192_resp got valid=%b resp=%h", resp_valid, resp_out); end
        step();
    endtask

    task automatic test_bad_key();
        frame_in    = mk_frame(8'h03, K256, PT);
        frame_valid = 1'b1;
        step();
        for (int i = 1; i <= 3; i++) begin
            checks++; if (aes_start !== 1'b0) begin errors++; $display("FAIL bad_no_start cyc %0d got %b want 0", i, aes_start); end
            step();
        end
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL bad_valid_latency got %b want 1", resp_valid); end
        checks++; if (resp_out !== {8'h80, 384'h0}) begin errors++; $display("FAIL bad_resp got %h want %h", resp_out, {8'h80, 384'h0}); end
        step();
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL bad_valid_width got %b want 0", resp_valid); end
        step(); step();
        checks++; if (busy !== 1'b0 || drop_count !== 8'd0) begin errors++; $display("FAIL bad_held_once got busy=%b drop=%0d want 0 0", busy, drop_count); end
        frame_valid = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        int n;
        bit got;
        send_frame(mk_frame(8'h00, {128'h0, K128}, PT));
        n = 0; got = 1'b0;
        while (!got && n < 200) begin
            step();
            n++;
            if (n == T + 1) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL to_busy_last_wait got %b want 1", busy); end
            end
            if (resp_valid === 1'b1) got = 1'b1;
        end
        checks++; if (!got || n != T + 4) begin errors++; $display("FAIL to_latency got seen=%b cycles=%0d want 1 %0d", got, n, T + 4); end
        checks++; if (resp_out !== {8'h81, 384'h0}) begin errors++; $display("FAIL to_resp got %h want %h", resp_out, {8'h81, 384'h0}); end
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_idle got busy=%b want 0", busy); end
    endtask

    task automatic test_overrun();
        send_frame(mk_frame(8'h00, {128'h0, K128}, PT));
        step(); step();
        frame_in    = mk_frame(8'h02, K256, ~PT);
        frame_valid = 1'b1;
        step();
        frame_valid = 1'b0;
        checks++; if (drop_count !== 8'd1) begin errors++; $display("FAIL ovr_drop got %0d want 1", drop_count); end
        checks++; if (aes_key !== {128'h0, K128} || aes_text !== PT) begin errors++; $display("FAIL ovr_key_stable got key=%h text=%h", aes_key, aes_text); end
        aes_done = 1'b1; aes_result = R128;
        step();
        aes_done = 1'b0;
        step();
        checks++; if (resp_valid !== 1'b1 || resp_out !== {8'h01, 256'h0, R128}) begin errors++; $display("FAIL ovr_resp got valid=%b resp=%h", resp_valid, resp_out); end
        step(); step(); step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovr_no_restart got busy=%b want 0", busy); end
    endtask

    task automatic test_reset_in_wait();
        int valids;
        send_frame(mk_frame(8'h00, {128'h0, K128}, PT));
        step(); step();
        reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_wait_busy got %b want 0", busy); end
        checks++; if (drop_count !== 8'd0 || resp_out !== '0) begin errors++; $display("FAIL rst_wait_clear got drop=%0d resp=%h", drop_count, resp_out); end
        step();
        reset = 1'b1;
        step();
        aes_done = 1'b1; aes_result = R128;
        valids = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            aes_done = 1'b0;
            if (resp_valid === 1'b1) valids++;
        end
        checks++; if (valids != 0 || busy !== 1'b0) begin errors++; $display("FAIL rst_wait_late_done got valids=%0d busy=%b want 0 0", valids, busy); end
    endtask

    initial begin
        test_reset();
        test_aes128();
        test_aes256();
        test_aes192_decrypt();
        test_bad_key();
        test_timeout();
        test_overrun();
        test_reset_in_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_frame_ctrl.md
AES_FRAME_CTRL -- requirements
Module: aes_frame_ctrl

Interface
REQ-001 SHALL have parameter FRAME_W, default 392, SPI frame width in bits.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1024, maximum cycles to wait for AES core completion.
REQ-003 SHALL have port clk, input, 1, the single system clock.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port frame_in, input, FRAME_W, received frame from the SPI slave data_out.
REQ-006 SHALL have port frame_valid, input, 1, the SPI slave done level.
REQ-007 SHALL have port aes_start, output, 1, one-cycle start pulse to the AES core.
REQ-008 SHALL have port aes_decrypt, output, 1, 1 selects decryption, 0 selects encryption.
REQ-009 SHALL have port aes_key_size, output, 2, 00=128, 01=192, 10=256.
REQ-010 SHALL have port aes_key, output, 256, key right-aligned with unused MSBs zero.
REQ-011 SHALL have port aes_text, output, 128, plaintext or ciphertext block.
REQ-012 SHALL have port aes_done, input, 1, AES core completion pulse.
REQ-013 SHALL have port aes_result, input, 128, AES core output block, valid with aes_done.
REQ-014 SHALL have port resp_out, output, FRAME_W, response frame to the SPI slave data_in.
REQ-015 SHALL have port resp_valid, output, 1, one-cycle pulse when resp_out is updated.
REQ-016 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-017 SHALL have port drop_count, output, 8, saturating count of frames ignored while busy.

Function
REQ-018 SHALL define the frame layout as follows:
- [391:384] command byte: [1:0] key size, [2] decrypt flag, [7:3] ignored.
- Key occupies [K-1:0], where K is 128, 192 or 256.
- Text occupies [K+127:K].
REQ-019 SHALL detect a new frame on a 0->1 transition of frame_valid, registered internally; a held-high level SHALL count as one frame only.
REQ-020 SHALL implement the states IDLE, CAPTURE, START, WAIT, RESP and ERR.
REQ-021 SHALL go from IDLE to CAPTURE on a frame edge, latching frame_in in the same cycle.
REQ-022 SHALL, in CAPTURE, decode the command byte and drive aes_key, aes_text, aes_key_size and aes_decrypt from the latched frame.
- Key size 11 SHALL go to ERR.
- Any other key size SHALL go to START.
REQ-023 SHALL, in START, assert aes_start for exactly one cycle, clear the timeout counter, and go to WAIT.
REQ-024 SHALL, in WAIT, on aes_done:
- register aes_result into resp_out[127:0];
- set resp_out[391:384]=8'h01 and zero all other bits;
- go to RESP.
REQ-025 SHALL, in WAIT with no aes_done after TIMEOUT_CYC cycles counted from entering WAIT, go to ERR with status 8'h81.
REQ-026 SHALL, in ERR, load resp_out with status 8'h80 (bad key size) or 8'h81 (timeout) in [391:384], zero all other bits, and go to RESP.
REQ-027 SHALL, in RESP, pulse resp_valid for one cycle and return to IDLE; resp_out SHALL hold until the next response.
REQ-028 SHALL keep end-to-end latency fixed: resp_valid rises exactly 2 cycles after the aes_done cycle and exactly 3 cycles after the CAPTURE cycle on the bad-key path.
REQ-029 SHALL ignore a frame edge arriving while busy, leave the in-flight transaction unaffected, and increment drop_count, saturating at 255.
REQ-030 SHALL ignore aes_done outside WAIT.
REQ-031 SHALL hold aes_key, aes_text, aes_key_size and aes_decrypt stable from CAPTURE until the next CAPTURE.

Reset
REQ-032 SHALL, on reset low, immediately force the state to IDLE and reset all outputs to zero: aes_start, resp_valid, busy, drop_count, resp_out, aes_key, aes_text, aes_key_size and aes_decrypt.
REQ-033 SHALL, on reset asserted mid-transaction, abandon the transaction, issue no response, and ignore any later aes_done for it.
REQ-034 SHALL clear the frame_valid edge-detect register on reset, so that a frame_valid held high through reset release is not treated as a new frame.

Structure
REQ-035 SHALL place FRAME_W, the key-size codes, the status codes 8'h01/8'h80/8'h81 and the state encoding in shared package aes_frame_pkg.
REQ-036 SHALL use one combinational sub-module, frame_unpack, to map the latched frame and key size to key, text and a key-size-valid flag.

Verification
REQ-037 SHALL cover the 128-bit case:
- Stimulus: frame with key 000102030405060708090a0b0c0d0e0f, text 00112233445566778899aabbccddeeff, cmd 00; model returns 69c4e0d86a7b0430d8cdb78070b4c55a.
- Required response: resp_out[127:0] equals that value and [391:384]=01.
REQ-038 SHALL cover the 256-bit case:
- Stimulus: key 000102...1f, cmd 02, aes_done 20 cycles after aes_start.
- Required response: aes_key_size=10, one aes_start pulse, resp_valid exactly 2 cycles after aes_done.
REQ-039 SHALL cover a bad key size: cmd 03 -> no aes_start, resp_out[391:384]=80, resp_valid one pulse.
REQ-040 SHALL cover timeout: aes_done never asserted -> status 81 after TIMEOUT_CYC cycles in WAIT, then busy low.
REQ-041 SHALL cover overrun: a second frame_valid edge during WAIT -> drop_count=1 and the first response unaffected.
REQ-042 SHALL cover reset during WAIT: reset low -> busy 0 immediately; a later aes_done produces no resp_valid.
